// File: rtl/regread_scoreboard.sv
// regread_scoreboard: ID-stage register-read interlock with pending-write scoreboard, stall watchdog and stall counter
module regread_scoreboard #(
    parameter int MAX_STALL = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_read_rs,
    input  logic             id_read_rt,
    input  logic             id_wr_en,
    input  logic [4:0]       id_wr_reg,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [4:0]       wb_reg,
    input  logic             hang_clr,
    output logic             stall,
    output logic             issue,
    output logic [31:0]      busy_vec,
    output logic [CNT_W-1:0] stall_total,
    output logic             hang
);
    localparam int LW = $clog2(MAX_STALL + 1);

    typedef enum logic {ST_RUN, ST_STALL} state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_busy, w_busy_nxt, w_eff;
    logic [LW-1:0]    r_len, w_len_nxt;
    logic [CNT_W-1:0] r_total;
    logic             r_hang, w_haz, w_stall, w_issue, w_trip;

    assign w_eff   = r_busy & ~({31'b0, wb_valid} << wb_reg);
    assign w_haz   = (id_read_rs & w_eff[id_rs]) | (id_read_rt & w_eff[id_rt]) | (id_wr_en & w_eff[id_wr_reg]);
    assign w_stall = id_valid & ~flush & w_haz;
    assign w_issue = id_valid & ~flush & ~w_haz;
    assign w_trip  = w_stall & (w_len_nxt == LW'(MAX_STALL));

    assign stall       = w_stall;
    assign issue       = w_issue;
    assign busy_vec    = r_busy;
    assign stall_total = r_total;
    assign hang        = r_hang;

    // Writeback clears first, then an issuing writer sets, so the set wins; $0 never becomes busy
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid) w_busy_nxt[wb_reg] = 1'b0;
        if (w_issue & id_wr_en) w_busy_nxt[id_wr_reg] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Next FSM state and consecutive-stall length, saturating at MAX_STALL
    always_comb begin
        w_state_nxt = w_stall ? ST_STALL : ST_RUN;
        w_len_nxt   = '0;
        if (w_stall) w_len_nxt = (r_state == ST_RUN) ? LW'(1) : (r_len == LW'(MAX_STALL)) ? r_len : r_len + LW'(1);
    end

    // FSM state and stall-length registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // Pending-write scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else r_busy <= w_busy_nxt;
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_total <= '0;
        else if (w_stall && r_total != '1) r_total <= r_total + CNT_W'(1);
    end

    // Sticky watchdog; a trip in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hang <= 1'b0;
        else if (w_trip) r_hang <= 1'b1;
        else if (hang_clr) r_hang <= 1'b0;
    end
endmodule

// File: tb/tb_regread_scoreboard.sv
// tb_regread_scoreboard: directed checks of the scoreboard interlock, watchdog and stall counter
module tb_regread_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_read_rs, id_read_rt, id_wr_en, flush, wb_valid, hang_clr;
    logic [4:0] id_rs, id_rt, id_wr_reg, wb_reg;
    logic       stall, issue, hang;
    logic [31:0] busy_vec;
    logic [3:0] stall_total;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] cl [3] = '{5'd3, 5'd6, 5'd9};

    regread_scoreboard #(.MAX_STALL(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_read_rs(id_read_rs), .id_read_rt(id_read_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .flush(flush), .wb_valid(wb_valid), .wb_reg(wb_reg), .hang_clr(hang_clr),
        .stall(stall), .issue(issue), .busy_vec(busy_vec), .stall_total(stall_total), .hang(hang)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_read_rs = 0; id_read_rt = 0;
        id_wr_en = 0; id_wr_reg = 0; flush = 0; wb_valid = 0; wb_reg = 0; hang_clr = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        nxt();
        id_valid = 1; id_wr_en = 1; id_wr_reg = 5;
        #1;
        chk("rst_issue", 32'(issue), 1);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_total", 32'(stall_total), 0);
        chk("rst_hang", 32'(hang), 0);
        nxt();
        chk("rst_busy_hold", busy_vec, 0);
        rst_n = 1;
        #1;
        chk("raw_writer_issue", 32'(issue), 1);
        nxt();
        chk("raw_busy5", busy_vec, 32'h20);
        idle(); id_valid = 1; id_rs = 5; id_read_rs = 1;
        #1;
        chk("raw_stall", 32'(stall), 1);
        chk("raw_no_issue", 32'(issue), 0);
        nxt();
        chk("raw_stall2", 32'(stall), 1);
        nxt();
        wb_valid = 1; wb_reg = 5;
        #1;
        chk("raw_bypass_issue", 32'(issue), 1);
        chk("raw_bypass_stall", 32'(stall), 0);
        nxt();
        chk("raw_busy_clr", busy_vec, 0);
        chk("raw_total", 32'(stall_total), 2);
        idle(); id_valid = 1; id_wr_en = 1; id_wr_reg = 7;
        nxt();
        chk("unread_busy7", busy_vec, 32'h80);
        idle(); id_valid = 1; id_rt = 7; id_rs = 0; id_read_rs = 1;
        #1;
        chk("unread_rt_issue", 32'(issue), 1);
        id_read_rt = 1;
        #1;
        chk("read_rt_stall", 32'(stall), 1);
        nxt();
        idle(); wb_valid = 1; wb_reg = 7;
        nxt();
        chk("wb7_clr", busy_vec, 0);
        idle(); id_valid = 1; id_wr_en = 1; id_wr_reg = 0;
        #1;
        chk("r0_issue", 32'(issue), 1);
        nxt();
        chk("r0_busy", busy_vec, 0);
        idle(); id_valid = 1; id_wr_en = 1; id_wr_reg = 9;
        nxt();
        chk("waw_busy9", busy_vec, 32'h200);
        #1;
        chk("waw_stall", 32'(stall), 1);
        nxt();
        wb_valid = 1; wb_reg = 9;
        #1;
        chk("waw_wb_issue", 32'(issue), 1);
        nxt();
        chk("waw_set_wins", busy_vec, 32'h200);
        idle(); id_valid = 1; id_wr_en = 1; id_wr_reg = 3;
        nxt();
        chk("sc_busy3", busy_vec, 32'h208);
        wb_valid = 1; wb_reg = 3;
        #1;
        chk("sc_issue", 32'(issue), 1);
        nxt();
        chk("sc_set_wins", busy_vec, 32'h208);
        idle(); id_valid = 1; id_wr_en = 1; id_wr_reg = 6; wb_valid = 1; wb_reg = 4;
        nxt();
        chk("sc_diff_regs", busy_vec, 32'h248);
        idle();
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1; wb_reg = cl[i];
            nxt();
        end
        chk("cleanup_busy", busy_vec, 0);
        chk("total_4", 32'(stall_total), 4);
        idle(); id_valid = 1; id_wr_en = 1; id_wr_reg = 10;
        nxt();
        idle(); id_valid = 1; id_rs = 10; id_read_rs = 1;
        repeat (3) nxt();
        chk("wd_hang_before", 32'(hang), 0);
        chk("wd_total_7", 32'(stall_total), 7);
        nxt();
        chk("wd_hang_trip", 32'(hang), 1);
        chk("wd_total_8", 32'(stall_total), 8);
        idle(); hang_clr = 1;
        #1;
        chk("wd_clr_nostall", 32'(stall), 0);
        nxt();
        chk("wd_hang_cleared", 32'(hang), 0);
        idle(); id_valid = 1; id_rs = 10; id_read_rs = 1; hang_clr = 1;
        repeat (3) nxt();
        chk("wd_trip_wins_pre", 32'(hang), 0);
        nxt();
        chk("wd_trip_wins", 32'(hang), 1);
        chk("wd_total_12", 32'(stall_total), 12);
        hang_clr = 0;
        repeat (5) nxt();
        chk("total_sat", 32'(stall_total), 15);
        chk("stall_mid", 32'(stall), 1);
        rst_n = 0;
        #1;
        chk("arst_busy", busy_vec, 0);
        chk("arst_hang", 32'(hang), 0);
        chk("arst_total", 32'(stall_total), 0);
        chk("arst_issue", 32'(issue), 1);
        nxt();
        rst_n = 1;
        #1;
        chk("post_rst_issue", 32'(issue), 1);
        idle(); id_valid = 1; id_wr_en = 1; id_wr_reg = 12;
        nxt();
        chk("fl_busy12", busy_vec, 32'h1000);
        idle(); id_valid = 1; id_rs = 12; id_read_rs = 1; id_wr_en = 1; id_wr_reg = 13;
        #1;
        chk("fl_pre_stall", 32'(stall), 1);
        nxt();
        flush = 1;
        #1;
        chk("fl_stall", 32'(stall), 0);
        chk("fl_issue", 32'(issue), 0);
        nxt();
        chk("fl_no_set", busy_vec, 32'h1000);
        chk("fl_total", 32'(stall_total), 1);
        idle();
        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
